// File: rtl/calculator_pkg.sv
// Shared command and dispatcher-state types for the calculator command scheduler.
// The switch field is sized for the widest supported SW input; narrower builds leave the upper bits zero.
package calculator_pkg;

    localparam int CMD_SW_BITS = 32;

    typedef struct packed {
        logic [4:0]             buttons;
        logic [CMD_SW_BITS-1:0] sw;
    } cmd_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } sched_state_t;

    function automatic logic [4:0] lowest_onehot(input logic [4:0] b);
        return b & (~b + 5'd1);
    endfunction

endpackage

// File: rtl/calc_cmd_fifo.sv
// Synchronous show-ahead command queue: head visible combinationally, write lands one cycle later.
// A write while full is accepted only if a read happens in the same cycle; otherwise it is ignored.
module calc_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_vld_i,
    input  logic [W-1:0]             wr_dat_i,
    input  logic                     rd_rdy_i,
    output logic [W-1:0]             rd_dat_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          do_wr;
    logic          do_rd;

    assign full_o   = (count_q == FULL_CNT);
    assign empty_o  = (count_q == '0);
    assign count_o  = count_q;
    assign rd_dat_o = mem_q[rd_ptr_q];
    assign do_rd    = rd_rdy_i && !empty_o;
    assign do_wr    = wr_vld_i && (!full_o || do_rd);

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[wr_ptr_q] <= wr_dat_i;
        end
    end

    // Power-of-two depth lets the pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_rd) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({do_wr, do_rd})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/calc_cmd_scheduler.sv
// Debounces push buttons into a command queue and issues one command per start strobe; start follows a push by 2 cycles.
// Commands wait while busy is high; a push into a full queue is dropped with an overflow pulse. CALC_AUTOREPEAT_EN adds held-press repeat.
module calc_cmd_scheduler
    import calculator_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 256,
    parameter int FIFO_DEPTH      = 4,
    parameter int SW_BITS         = 16
) (
    input  logic                          clk,
    input  logic                          CPU_RESETN,
    input  logic [4:0]                    buttons,
    input  logic [SW_BITS-1:0]            SW,
    input  logic                          busy,
    output logic                          start,
    output logic [4:0]                    button_cmd,
    output logic [SW_BITS-1:0]            switch_cmd,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   pending
);
    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_CYCLES - 1);

    logic [4:0]      sync1_q;
    logic [4:0]      sync2_q;
    logic [4:0]      last_q;
    logic [DB_W-1:0] db_cnt_q;
    logic [DB_W-1:0] db_cnt_d;
    logic            armed_q;
    logic            armed_d;
    logic            stable;
    logic            first_push;
    logic            push;
    logic            pop;
    cmd_t            push_cmd;
    cmd_t            fifo_head;
    logic            fifo_full;
    logic            fifo_empty;

    sched_state_t       state_q;
    logic               start_q;
    logic [4:0]         button_cmd_q;
    logic [SW_BITS-1:0] switch_cmd_q;

    assign stable     = (sync2_q != '0) && (sync2_q == last_q);
    assign first_push = stable && armed_q && (db_cnt_q == DB_MAX);

    // Once a press has pushed, it must go back to all-zero before another one can.
    always_comb begin
        db_cnt_d = db_cnt_q;
        armed_d  = armed_q;
        if (!stable) begin
            db_cnt_d = '0;
        end else if (db_cnt_q != DB_MAX) begin
            db_cnt_d = db_cnt_q + DB_W'(1);
        end
        if (sync2_q == '0) begin
            armed_d = 1'b1;
        end else if (first_push) begin
            armed_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            last_q   <= '0;
            db_cnt_q <= '0;
            armed_q  <= 1'b1;
        end else begin
            sync1_q  <= buttons;
            sync2_q  <= sync1_q;
            last_q   <= sync2_q;
            db_cnt_q <= db_cnt_d;
            armed_q  <= armed_d;
        end
    end

`ifdef CALC_AUTOREPEAT_EN
    localparam int REP_FIRST = 16 * DEBOUNCE_CYCLES;
    localparam int REP_NEXT  = 4 * DEBOUNCE_CYCLES;
    localparam int RP_W      = $clog2(REP_FIRST + 1);
    localparam logic [RP_W-1:0] REP_FIRST_M1 = RP_W'(REP_FIRST - 1);
    localparam logic [RP_W-1:0] REP_NEXT_M1  = RP_W'(REP_NEXT - 1);

    logic [RP_W-1:0] rep_cnt_q;
    logic [RP_W-1:0] rep_cnt_d;
    logic            rep_next_q;
    logic            rep_next_d;
    logic            rep_push;

    // Repeat timer runs only after the first push of a still-held press.
    always_comb begin
        rep_push   = stable && !armed_q &&
                     (rep_cnt_q == (rep_next_q ? REP_NEXT_M1 : REP_FIRST_M1));
        rep_cnt_d  = rep_cnt_q + RP_W'(1);
        rep_next_d = rep_next_q;
        if (!stable || armed_q) begin
            rep_cnt_d  = '0;
            rep_next_d = 1'b0;
        end else if (rep_push) begin
            rep_cnt_d  = '0;
            rep_next_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            rep_cnt_q  <= '0;
            rep_next_q <= 1'b0;
        end else begin
            rep_cnt_q  <= rep_cnt_d;
            rep_next_q <= rep_next_d;
        end
    end

    assign push = first_push || rep_push;
`else
    assign push = first_push;
`endif

    assign push_cmd.buttons = lowest_onehot(sync2_q);
    assign push_cmd.sw      = CMD_SW_BITS'(SW);
    assign pop              = (state_q == ISSUE);
    assign overflow         = push && fifo_full && !pop;

    calc_cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     ($bits(cmd_t))
    ) u_fifo (
        .clk      (clk),
        .rst_n    (CPU_RESETN),
        .wr_vld_i (push),
        .wr_dat_i (push_cmd),
        .rd_rdy_i (pop),
        .rd_dat_o (fifo_head),
        .full_o   (fifo_full),
        .empty_o  (fifo_empty),
        .count_o  (pending)
    );

    always_ff @(posedge clk or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            state_q      <= IDLE;
            start_q      <= 1'b0;
            button_cmd_q <= '0;
            switch_cmd_q <= '0;
        end else begin
            start_q      <= 1'b0;
            button_cmd_q <= '0;
            switch_cmd_q <= '0;
            case (state_q)
                IDLE: begin
                    if (!fifo_empty && !busy) begin
                        state_q      <= ISSUE;
                        start_q      <= 1'b1;
                        button_cmd_q <= fifo_head.buttons;
                        switch_cmd_q <= SW_BITS'(fifo_head.sw);
                    end
                end
                ISSUE: state_q <= WAIT;
                WAIT: begin
                    if (!busy) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign start      = start_q;
    assign button_cmd = button_cmd_q;
    assign switch_cmd = switch_cmd_q;

endmodule

// File: doc/calc_cmd_scheduler.md
CALC_CMD_SCHEDULER -- requirements
Module: calc_cmd_scheduler

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 256, meaning consecutive stable cycles required to accept a press.
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 4 (power of two, at least 2), meaning command queue entries.
REQ-003 The block SHALL have parameter SW_BITS, default 16, meaning captured switch width.
REQ-004 The block SHALL have port clk, input, 1 bit, the single clock; all logic is in this domain.
REQ-005 The block SHALL have port CPU_RESETN, input, 1 bit, asynchronous active-low reset.
REQ-006 The block SHALL have port buttons, input, 5 bits, raw asynchronous push buttons.
REQ-007 The block SHALL have port SW, input, SW_BITS bits, raw switches captured with each accepted press.
REQ-008 The block SHALL have port busy, input, 1 bit, high while the calculator datapath is processing.
REQ-009 The block SHALL have port start, output, 1 bit, one-cycle command strobe to the calculator.
REQ-010 The block SHALL have port button_cmd, output, 5 bits, one-hot button code, valid while start is high.
REQ-011 The block SHALL have port switch_cmd, output, SW_BITS bits, switch value, valid while start is high.
REQ-012 The block SHALL have port overflow, output, 1 bit, one-cycle pulse when a command is dropped.
REQ-013 The block SHALL have port pending, output, clog2(FIFO_DEPTH)+1 bits, current FIFO occupancy.

Function
REQ-014 buttons SHALL pass through a 2-flop synchronizer; SW SHALL be sampled at the push cycle, with no synchronizer needed because switches are quasi-static.
REQ-015 Debounce: counter SHALL advance while the synchronized buttons are nonzero and unchanged, and SHALL clear on any change or all-zero.
REQ-016 When the counter reaches DEBOUNCE_CYCLES-1, exactly one command SHALL be pushed; further pushes require release to all-zero first.
REQ-017 With multiple buttons pressed, the lowest-index button SHALL win; button_cmd SHALL always be one-hot.
REQ-018 A release before DEBOUNCE_CYCLES SHALL push nothing.
REQ-019 FIFO full at push without a same-cycle pop: the command SHALL be dropped and overflow SHALL pulse for 1 cycle.
REQ-020 FIFO full with push and pop in the same cycle: the push SHALL be accepted and overflow SHALL stay low.
REQ-021 Dispatcher FSM SHALL have states IDLE, ISSUE and WAIT.
REQ-022 IDLE to ISSUE SHALL occur when the FIFO is non-empty and busy is 0.
REQ-023 ISSUE SHALL last 1 cycle: start=1, button_cmd/switch_cmd come from the FIFO head, the head is popped, then the FSM goes to WAIT.
REQ-024 WAIT SHALL hold for at least 1 cycle, then return to IDLE on the first cycle with busy=0.
REQ-025 Latency: a push at cycle N into an empty FIFO with busy=0 SHALL give start=1 at cycle N+2.
REQ-026 With busy tied to 0, back-to-back commands SHALL issue every 3 cycles.
REQ-027 When start is 0, button_cmd and switch_cmd SHALL be 0.
REQ-028 FIFO pointers SHALL wrap modulo FIFO_DEPTH; pending SHALL saturate neither below 0 nor above FIFO_DEPTH.

Reset
REQ-029 Assertion of CPU_RESETN=0 SHALL immediately set start=0, button_cmd=0, switch_cmd=0, overflow=0, pending=0, FSM=IDLE, FIFO empty, debounce counter=0 and synchronizers=0.
REQ-030 Reset during ISSUE or WAIT SHALL discard all queued and in-flight commands; no start SHALL follow release until a new press is debounced.
REQ-031 Reset deassertion SHALL be synchronized to clk externally; the block SHALL assume nothing else about it.

Configuration
REQ-032 Macro CALC_AUTOREPEAT_EN defined: a press held stable for 16*DEBOUNCE_CYCLES after its first push SHALL push a repeat command, then another every 4*DEBOUNCE_CYCLES until release.
REQ-033 Macro CALC_AUTOREPEAT_EN undefined: exactly one command per press, with no repeat counter logic present.

Structure
REQ-034 calculator_pkg SHALL hold the cmd_t struct {buttons[4:0], sw[SW_BITS-1:0]} and the sched_state_t enum {IDLE, ISSUE, WAIT}.
REQ-035 The queue SHALL be a sub-module calc_cmd_fifo (synchronous, show-ahead head, full/empty/count outputs).

Verification
REQ-036 Test 1: buttons=5'b00100, SW=16'h00A5 held 300 cycles, busy=0 -> single start with button_cmd=5'b00100, switch_cmd=16'h00A5, at push+2.
REQ-037 Test 2: buttons=5'b00010 for 100 cycles then released -> no start, pending=0.
REQ-038 Test 3: buttons=5'b10110 held -> button_cmd=5'b00010.
REQ-039 Test 4: busy=1, 5 separate presses -> pending=4, overflow pulses once; busy=0 -> 4 starts in press order, 3 cycles apart.
REQ-040 Test 5: CPU_RESETN=0 during WAIT with pending=3 -> outputs 0, pending=0; no start after release.
REQ-041 Test 6 (CALC_AUTOREPEAT_EN defined): hold buttons=5'b00001 for 16*256+2*4*256+50 cycles -> 3 starts.
